// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-Lite response codes, master FSM states and width defaults
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
  } master_state_e;

  localparam int AXI_ADDR_W      = 32;
  localparam int AXI_DATA_W      = 32;
  localparam int AXI_TIMEOUT_CYC = 256;

endpackage

// File: rtl/axi4lite_master.sv
// rtl/axi4lite_master.sv - single-outstanding AXI4-Lite initiator with per-phase handshake timeout
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W      = AXI_ADDR_W,
  parameter int DATA_W      = AXI_DATA_W,
  parameter int TIMEOUT_CYC = AXI_TIMEOUT_CYC,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              A_CLK,
  input  logic              A_RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic [2:0]        AW_PROT,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP,
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic [2:0]        AR_PROT,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP
);

  // Abort fires on the last allowed cycle of a phase when no handshake happens in it.
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [15:0] TMO_LAST = (TIMEOUT_CYC == 0)    ? 16'd0 :
                                     (TIMEOUT_CYC > 65536) ? 16'hFFFF :
                                                             16'(TIMEOUT_CYC - 1);

  master_state_e     state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [2:0]        prot_q, prot_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic              tmo_hit;
  logic              abort;

  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    prot_d        = prot_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    b_ready_d     = b_ready_q;
    ar_valid_d    = ar_valid_q;
    r_ready_d     = r_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d   = 1'b0;
          addr_d        = req_addr;
          wdata_d       = req_wdata;
          wstrb_d       = req_wstrb;
          prot_d        = req_prot;
          rsp_timeout_d = 1'b0;
          if (req_write) begin
            state_d    = ST_WR_AW_W;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = ST_RD_AR;
            ar_valid_d = 1'b1;
          end
        end
      end
      ST_WR_AW_W: begin
        // A low VALID register doubles as that channel's done flag.
        if (AW_READY) aw_valid_d = 1'b0;
        if (W_READY)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = ST_WR_B;
          b_ready_d = 1'b1;
        end else begin
          abort = tmo_hit;
        end
      end
      ST_WR_B: begin
        if (B_VALID) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = B_RESP;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end else begin
          abort = tmo_hit;
        end
      end
      ST_RD_AR: begin
        if (AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = ST_RD_R;
        end else begin
          abort = tmo_hit;
        end
      end
      ST_RD_R: begin
        if (R_VALID) begin
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = R_RESP;
          rsp_rdata_d = R_DATA;
          state_d     = ST_RSP;
        end else begin
          abort = tmo_hit;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase

    if (abort) begin
      aw_valid_d    = 1'b0;
      w_valid_d     = 1'b0;
      b_ready_d     = 1'b0;
      ar_valid_d    = 1'b0;
      r_ready_d     = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RSP;
    end

    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_RSP)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == 16'hFFFF) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      prot_q        <= '0;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      b_ready_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      r_ready_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      prot_q        <= prot_d;
      aw_valid_q    <= aw_valid_d;
      w_valid_q     <= w_valid_d;
      b_ready_q     <= b_ready_d;
      ar_valid_q    <= ar_valid_d;
      r_ready_q     <= r_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AW_VALID    = aw_valid_q;
  assign AW_ADDR     = addr_q;
  assign AW_PROT     = prot_q;
  assign W_VALID     = w_valid_q;
  assign W_DATA      = wdata_q;
  assign W_STRB      = wstrb_q;
  assign B_READY     = b_ready_q;
  assign AR_VALID    = ar_valid_q;
  assign AR_ADDR     = addr_q;
  assign AR_PROT     = prot_q;
  assign R_READY     = r_ready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// tb/tb_axi4lite_master.sv - scoreboard bench for axi4lite_master against a behavioural memory slave
module tb_axi4lite_master;

  localparam int TMO = 8;

  logic        A_CLK = 1'b0;
  logic        A_RST;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [31:0] AW_ADDR, AR_ADDR, W_DATA, R_DATA;
  logic [2:0]  AW_PROT, AR_PROT;
  logic [3:0]  W_STRB;
  logic [1:0]  B_RESP, R_RESP;

  axi4lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  always #5 A_CLK = ~A_CLK;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          tmo;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] slv_mem[int];
  int          n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          rnd_dly = 0, hang_ar = 0, slave_abort = 0, rsp_rand = 0;
  int          rsp_block = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int dly(int fixed);
    return rnd_dly ? int'($urandom_range(0, 4)) : fixed;
  endfunction

  // Slave error region: 0xF0-0xFF answers SLVERR for writes, DECERR for reads.
  function automatic bit is_err(logic [31:0] a);
    return a[7:4] == 4'hF;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] m = old;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  initial begin
    forever begin
      @(posedge A_CLK);
      cyc++;
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input bit lat);
    exp_t e;
    int   idx = int'(a[31:2]);
    int   g = 0;
    e.w = w; e.addr = a; e.wdata = d; e.strb = s; e.prot = p; e.lat = lat;
    e.tmo = !w && hang_ar;
    e.rdata = '0;
    if (e.tmo) begin
      e.resp = 2'b10;
    end else if (w) begin
      e.resp = is_err(a) ? 2'b10 : 2'b00;
      if (!is_err(a)) ref_mem[idx] = merge(ref_mem.exists(idx) ? ref_mem[idx] : 32'h0, d, s);
    end else begin
      e.resp = is_err(a) ? 2'b11 : 2'b00;
      if (!is_err(a) && ref_mem.exists(idx)) e.rdata = ref_mem[idx];
    end
    exp_q.push_back(e);
    @(posedge A_CLK); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_prot = p;
    do begin
      @(negedge A_CLK);
      g++;
    end while (!req_ready && g < 200);
    chk("req_accept", 64'(req_ready), 64'(1));
    last_acc = cyc;
    @(posedge A_CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() > 0 && g < 1000) begin
      @(negedge A_CLK);
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_flags"}, 64'({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid,
                              rsp_timeout, req_ready}), 64'(8'b0000_0001));
    chk({tag, "_addr_data"}, {AW_ADDR, W_DATA}, 64'(0));
    chk({tag, "_misc"}, 64'({W_STRB, AW_PROT, AR_PROT, rsp_resp, AR_ADDR}), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
  endtask

  task automatic slave_write();
    exp_t        e = '{default: '0};
    int          ad = dly(aw_dly), wd = dly(w_dly), bd, g = 0, idx;
    bit          ag = 0, wg = 0, bg = 0;
    logic [31:0] a = '0, d = '0;
    logic [3:0]  s = '0;
    if (exp_q.size() > 0) e = exp_q[0];
    if (e.lat) chk("aw_w_latency", 64'(cyc - last_acc), 64'(1));
    while (!(ag && wg) && !slave_abort && g < 200) begin
      if (wg) chk("w_dropped_aw_held", 64'({W_VALID, AW_VALID}), 64'(2'b01));
      if (ag) chk("aw_dropped_w_held", 64'({AW_VALID, W_VALID}), 64'(2'b01));
      if (!ag) begin if (ad == 0) AW_READY = 1'b1; else ad--; end
      if (!wg) begin if (wd == 0) W_READY = 1'b1; else wd--; end
      if (AW_READY && AW_VALID) begin
        ag = 1; a = AW_ADDR;
        chk("aw_addr", 64'(AW_ADDR), 64'(e.addr));
        chk("aw_prot", 64'(AW_PROT), 64'(e.prot));
      end
      if (W_READY && W_VALID) begin
        wg = 1; d = W_DATA; s = W_STRB;
        chk("w_data", 64'(W_DATA), 64'(e.wdata));
        chk("w_strb", 64'(W_STRB), 64'(e.strb));
      end
      @(posedge A_CLK); #1;
      AW_READY = 1'b0; W_READY = 1'b0;
      @(negedge A_CLK);
      g++;
    end
    if (ag && wg) begin
      idx = int'(a[31:2]);
      if (!is_err(a)) slv_mem[idx] = merge(slv_mem.exists(idx) ? slv_mem[idx] : 32'h0, d, s);
      bd = dly(b_dly);
      while (!bg && !slave_abort && g < 200) begin
        if (bd == 0) begin B_VALID = 1'b1; B_RESP = is_err(a) ? 2'b10 : 2'b00; end
        else bd--;
        if (B_VALID && B_READY) bg = 1;
        @(posedge A_CLK); #1;
        if (bg) B_VALID = 1'b0;
        @(negedge A_CLK);
        g++;
      end
      B_VALID = 1'b0;
      if (bg) chk("b_ready_dropped", 64'(B_READY), 64'(0));
    end
  endtask

  task automatic slave_read();
    exp_t        e = '{default: '0};
    int          ad = dly(ar_dly), rd, g = 0, hv = 0, idx;
    bit          ag = 0, rg = 0;
    logic [31:0] a = '0;
    if (exp_q.size() > 0) e = exp_q[0];
    if (e.lat) chk("ar_latency", 64'(cyc - last_acc), 64'(1));
    if (hang_ar) begin
      while (AR_VALID && g < 100) begin
        hv++;
        @(negedge A_CLK);
        g++;
      end
      chk("ar_valid_cycles_before_timeout", 64'(hv), 64'(TMO));
      return;
    end
    while (!ag && !slave_abort && g < 200) begin
      if (ad == 0) AR_READY = 1'b1; else ad--;
      if (AR_READY && AR_VALID) begin
        ag = 1; a = AR_ADDR;
        chk("ar_addr", 64'(AR_ADDR), 64'(e.addr));
        chk("ar_prot", 64'(AR_PROT), 64'(e.prot));
      end
      @(posedge A_CLK); #1;
      AR_READY = 1'b0;
      @(negedge A_CLK);
      g++;
    end
    if (ag) begin
      idx = int'(a[31:2]);
      rd  = dly(r_dly);
      while (!rg && !slave_abort && g < 200) begin
        if (rd == 0) begin
          R_VALID = 1'b1;
          R_RESP  = is_err(a) ? 2'b11 : 2'b00;
          R_DATA  = (!is_err(a) && slv_mem.exists(idx)) ? slv_mem[idx] : 32'h0;
        end else rd--;
        if (R_VALID && R_READY) rg = 1;
        @(posedge A_CLK); #1;
        if (rg) R_VALID = 1'b0;
        @(negedge A_CLK);
        g++;
      end
      R_VALID = 1'b0;
    end
  endtask

  initial begin
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
    forever begin
      @(negedge A_CLK);
      if (!A_RST) begin
        if (AW_VALID || W_VALID) slave_write();
        else if (AR_VALID) slave_read();
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge A_CLK); #1;
      if (rsp_block > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        rsp_block--;
      end else begin
        rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    bit   prev = 0;
    int   rise = 0;
    exp_t e;
    forever begin
      @(negedge A_CLK);
      if (A_RST) begin
        prev = 0;
      end else begin
        if (rsp_valid && !prev) rise = cyc;
        prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            if (e.lat) chk("rsp_latency", 64'(rise - last_acc), 64'(3));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    logic [31:0] a, d;
    A_RST = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_prot = 0;
    repeat (3) @(posedge A_CLK);
    @(negedge A_CLK);
    chk_reset("reset");
    A_RST = 1'b0;

    issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, 1'b1);
    wait_done();
    issue(1'b0, 32'h4, 32'h0, 4'h0, 3'b010, 1'b1);
    wait_done();

    aw_dly = 3;
    issue(1'b1, 32'h8, 32'hA5A5_1234, 4'hF, 3'b001, 1'b0);
    wait_done();
    aw_dly = 0;

    hang_ar = 1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0);
    wait_done();
    hang_ar = 0;
    issue(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b0);
    wait_done();

    rsp_block = 5;
    issue(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b0);
    g = 0;
    do begin
      @(negedge A_CLK);
      g++;
    end while (!rsp_valid && g < 50);
    chk("hold_rsp_seen", 64'(rsp_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge A_CLK);
      chk("hold_valid_reqready", 64'({rsp_valid, req_ready}), 64'(2'b10));
      chk("hold_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    end
    wait_done();

    b_dly = 20;
    issue(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 3'b000, 1'b0);
    g = 0;
    do begin
      @(negedge A_CLK);
      g++;
    end while (!B_READY && g < 50);
    chk("in_wr_b", 64'(B_READY), 64'(1));
    A_RST = 1'b1;
    slave_abort = 1;
    exp_q.delete();
    @(posedge A_CLK); #1;
    A_RST = 1'b0;
    @(negedge A_CLK);
    chk_reset("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge A_CLK);
      chk("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
    end
    slave_abort = 0;
    b_dly = 0;

    rnd_dly = 1;
    rsp_rand = 1;
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hF0 + 4 * $urandom_range(0, 3)
                                      : 4 * $urandom_range(0, 31);
      d = $urandom;
      issue(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 1'b0);
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
